// File: rtl/bus_control_nway.sv
// bus_control_nway: round-robin snooping bus controller between NCACHE L1 dcaches and one RAM port.
// Ports:
//   CLK, RST                        clock, asynchronous active-high reset
//   cache_ren/wen/rdx/addr/store    per-cache block read, writeback, exclusive flag, address, writeback word
//   cache_load, cache_wait          broadcast fill word, active-low per-cache word-done strobe
//   grant, word_idx                 one-hot bus owner, current word within the block
//   snoop_valid/inv/addr            snoop strobe, invalidate and block address to non-granted caches
//   snoop_hit, snoop_data           Modified-hit flags and supplier words from snooped caches
//   ram_ren/wen/addr/store/load     RAM word access
//   ram_ready                       RAM access completes this cycle
module bus_control_nway #(
  parameter int NCACHE = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WORDS  = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NCACHE-1:0]          cache_ren,
  input  logic [NCACHE-1:0]          cache_wen,
  input  logic [NCACHE-1:0]          cache_rdx,
  input  logic [NCACHE*ADDR_W-1:0]   cache_addr,
  input  logic [NCACHE*DATA_W-1:0]   cache_store,
  output logic [DATA_W-1:0]          cache_load,
  output logic [NCACHE-1:0]          cache_wait,
  output logic [NCACHE-1:0]          grant,
  output logic [$clog2(WORDS)-1:0]   word_idx,
  output logic [NCACHE-1:0]          snoop_valid,
  output logic [NCACHE-1:0]          snoop_inv,
  output logic [ADDR_W-1:0]          snoop_addr,
  input  logic [NCACHE-1:0]          snoop_hit,
  input  logic [NCACHE*DATA_W-1:0]   snoop_data,
  output logic                       ram_ren,
  output logic                       ram_wen,
  output logic [ADDR_W-1:0]          ram_addr,
  output logic [DATA_W-1:0]          ram_store,
  input  logic [DATA_W-1:0]          ram_load,
  input  logic                       ram_ready
);
  localparam int WI = $clog2(WORDS);
  localparam int GW = $clog2(NCACHE);
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(WORDS*4-1);
  typedef enum logic [2:0] {S_IDLE, S_SNOOP, S_MEMRD, S_C2C, S_WB} state_t;
  state_t            r_state, w_next;
  logic [NCACHE-1:0] r_grant, w_req, w_hits;
  logic [GW-1:0]     r_g, r_rr, r_sup, w_pick, w_j, w_hit_idx;
  logic [WI-1:0]     r_widx;
  logic [ADDR_W-1:0] r_base;
  logic              w_found, w_xfer, w_last;
  logic [DATA_W-1:0] w_sup_data;
  assign w_req      = cache_ren | cache_wen;
  assign w_hits     = snoop_hit & ~r_grant;
  assign w_xfer     = ram_ready && (r_state inside {S_MEMRD, S_C2C, S_WB});
  assign w_last     = w_xfer && (r_widx == WI'(WORDS-1));
  assign w_sup_data = snoop_data[r_sup*DATA_W +: DATA_W];
  // Round-robin: first requester after the last owner, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_j     = '0;
    for (int k = 1; k <= NCACHE; k++) begin
      w_j = GW'((int'(r_rr) + k) % NCACHE);
      if (!w_found && w_req[w_j]) begin
        w_found = 1'b1;
        w_pick  = w_j;
      end
    end
  end
  // Lowest hitting index supplies, even if several caches claim Modified.
  always_comb begin
    w_hit_idx = '0;
    for (int i = NCACHE-1; i >= 0; i--)
      if (w_hits[i]) w_hit_idx = GW'(i);
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next = cache_wen[w_pick] ? S_WB : S_SNOOP;
      S_SNOOP: w_next = (|w_hits) ? S_C2C : S_MEMRD;
      default: if (w_last) w_next = S_IDLE;
    endcase
  end
  assign grant       = r_grant;
  assign word_idx    = r_widx;
  assign snoop_valid = (r_state == S_SNOOP) ? ~r_grant : '0;
  assign snoop_inv   = (r_state == S_SNOOP && cache_rdx[r_g]) ? ~r_grant : '0;
  assign snoop_addr  = (r_state == S_SNOOP) ? r_base : '0;
  assign ram_ren     = r_state == S_MEMRD;
  assign ram_wen     = r_state inside {S_C2C, S_WB};
  assign ram_addr    = (ram_ren || ram_wen) ? r_base + ADDR_W'({r_widx, 2'b00}) : '0;
  // Cache-to-cache data goes to the requester and RAM in the same beat.
  assign cache_load  = (r_state == S_MEMRD) ? ram_load : (r_state == S_C2C) ? w_sup_data : '0;
  assign ram_store   = (r_state == S_C2C) ? w_sup_data :
                       (r_state == S_WB) ? cache_store[r_g*DATA_W +: DATA_W] : '0;
  assign cache_wait  = ~(r_grant & {NCACHE{w_xfer}});
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_g     <= '0;
      r_rr    <= GW'(NCACHE-1);
      r_sup   <= '0;
      r_widx  <= '0;
      r_base  <= '0;
    end else begin
      r_state <= w_next;
      if (w_xfer) r_widx <= r_widx + 1'b1;
      if (r_state == S_IDLE && w_found) begin
        r_grant <= NCACHE'(1) << w_pick;
        r_g     <= w_pick;
        r_base  <= cache_addr[w_pick*ADDR_W +: ADDR_W] & BASE_MASK;
      end
      if (r_state == S_SNOOP) r_sup <= w_hit_idx;
      if (w_last) begin
        r_grant <= '0;
        r_rr    <= r_g;
      end
    end
endmodule

// File: tb/tb_bus_control_nway.sv
// tb_bus_control_nway: scoreboard bench for bus_control_nway with cache, snooper and RAM models.
module tb_bus_control_nway;
  localparam int NC = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int WD = 2;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic [NC-1:0] cache_ren = '0, cache_wen = '0, cache_rdx = '0, snoop_hit = '0;
  logic [NC*AW-1:0] cache_addr = '0;
  logic [NC*DW-1:0] cache_store, snoop_data;
  logic [DW-1:0] cache_load, ram_store, ram_load;
  logic [NC-1:0] cache_wait, grant, snoop_valid, snoop_inv;
  logic [$clog2(WD)-1:0] word_idx;
  logic [AW-1:0] snoop_addr, ram_addr;
  logic ram_ren, ram_wen;
  logic ram_ready = 1'b0;
  bit rdy_rand = 1'b0;
  always #5 CLK = ~CLK;
  bus_control_nway #(.NCACHE(NC), .ADDR_W(AW), .DATA_W(DW), .WORDS(WD)) dut (
    .CLK(CLK), .RST(RST), .cache_ren(cache_ren), .cache_wen(cache_wen), .cache_rdx(cache_rdx),
    .cache_addr(cache_addr), .cache_store(cache_store), .cache_load(cache_load), .cache_wait(cache_wait),
    .grant(grant), .word_idx(word_idx), .snoop_valid(snoop_valid), .snoop_inv(snoop_inv),
    .snoop_addr(snoop_addr), .snoop_hit(snoop_hit), .snoop_data(snoop_data), .ram_ren(ram_ren),
    .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready));
  function automatic logic [DW-1:0] init_val(input logic [7:0] i);
    return {8'hA5, i, 8'h5A, ~i};
  endfunction
  // RAM model: 256 words, unwritten words read back their initial pattern.
  logic [DW-1:0] ram_mem [256];
  bit ram_wr [256];
  assign ram_load = ram_wr[ram_addr[9:2]] ? ram_mem[ram_addr[9:2]] : init_val(ram_addr[9:2]);
  always @(posedge CLK)
    if (!RST && ram_wen && ram_ready) begin
      ram_mem[ram_addr[9:2]] <= ram_store;
      ram_wr[ram_addr[9:2]]  <= 1'b1;
    end
  initial forever begin
    @(posedge CLK);
    #1 ram_ready = rdy_rand ? ($urandom_range(0, 9) < 6) : ~ram_ready;
  end
  // Cache and snooper models present the word selected by word_idx.
  logic [DW-1:0] st [NC][WD];
  logic [DW-1:0] sd [NC][WD];
  always_comb begin
    cache_store = '0;
    snoop_data  = '0;
    for (int i = 0; i < NC; i++) begin
      cache_store[i*DW +: DW] = st[i][word_idx];
      snoop_data[i*DW +: DW]  = sd[i][word_idx];
    end
  end
  // Reference model state.
  bit pren [NC], pwen [NC], prdx [NC];
  logic [AW-1:0] paddr [NC];
  logic [DW-1:0] mdl_mem [256];
  int rr = NC-1;
  typedef struct {logic [NC-1:0] g; logic ren; logic wen; logic [AW-1:0] addr; logic [DW-1:0] load; logic [DW-1:0] store; bit cl; bit cs;} wexp_t;
  typedef struct {logic [NC-1:0] v; logic [NC-1:0] inv; logic [AW-1:0] a;} sexp_t;
  wexp_t wq [$];
  sexp_t sq [$];
  logic [NC-1:0] gq [$];
  int checks = 0;
  int errors = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic apply();
    for (int i = 0; i < NC; i++) begin
      cache_ren[i] = pren[i];
      cache_wen[i] = pwen[i];
      cache_rdx[i] = prdx[i];
      cache_addr[i*AW +: AW] = paddr[i];
    end
  endtask
  task automatic new_req(input int i);
    int r;
    r = $urandom_range(1, 3);
    pren[i] = r[0];
    pwen[i] = r[1];
    prdx[i] = $urandom_range(0, 1) == 1;
    paddr[i] = AW'($urandom_range(0, 255) * 4);
    for (int k = 0; k < WD; k++) st[i][k] = $urandom;
  endtask
  task automatic add_random(input int excl);
    for (int i = 0; i < NC; i++)
      if (i != excl && !pren[i] && !pwen[i] && $urandom_range(0, 2) == 0) new_req(i);
  endtask
  task automatic check_reset_outputs();
    logic [NC-1:0] ones;
    ones = '1;
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_cache_wait", 64'(cache_wait), 64'(ones));
    chk("rst_snoop_valid", 64'(snoop_valid), 64'(0));
    chk("rst_snoop_inv", 64'(snoop_inv), 64'(0));
    chk("rst_snoop_addr", 64'(snoop_addr), 64'(0));
    chk("rst_ram_ren", 64'(ram_ren), 64'(0));
    chk("rst_ram_wen", 64'(ram_wen), 64'(0));
    chk("rst_ram_addr", 64'(ram_addr), 64'(0));
    chk("rst_ram_store", 64'(ram_store), 64'(0));
    chk("rst_cache_load", 64'(cache_load), 64'(0));
    chk("rst_word_idx", 64'(word_idx), 64'(0));
  endtask
  // Asynchronous reset pulse started between clock edges.
  task automatic pulse_reset();
    #2 RST = 1'b1;
    #1 check_reset_outputs();
    wq.delete();
    sq.delete();
    gq.delete();
    rr = NC-1;
    @(negedge CLK);
    RST = 1'b0;
  endtask
  // One bus transaction: predict from the pending-request model, then drive and wait.
  task automatic do_txn(input bit hold, input bit rnd, input logic [NC-1:0] sh, input int abort_after);
    int w, sup, j;
    bit wb, ok;
    logic [NC-1:0] oh, nv, ni;
    logic [AW-1:0] base, a;
    logic [DW-1:0] d;
    w = -1;
    for (int k = 1; k <= NC; k++) begin
      j = (rr + k) % NC;
      if (w < 0 && (pren[j] || pwen[j])) w = j;
    end
    if (w < 0) return;
    snoop_hit = sh;
    oh = NC'(1) << w;
    wb = pwen[w];
    base = paddr[w] & ~32'(WD*4-1);
    gq.push_back(oh);
    sup = -1;
    if (!wb) begin
      nv = ~oh;
      ni = prdx[w] ? nv : '0;
      sq.push_back('{nv, ni, base});
      for (int i = NC-1; i >= 0; i--) if (sh[i] && i != w) sup = i;
    end
    for (int k = 0; k < WD; k++) begin
      a = base + 32'(4*k);
      if (wb) begin
        d = st[w][k];
        mdl_mem[a[9:2]] = d;
        wq.push_back('{oh, 1'b0, 1'b1, a, '0, d, 1'b0, 1'b1});
      end else if (sup >= 0) begin
        d = sd[sup][k];
        mdl_mem[a[9:2]] = d;
        wq.push_back('{oh, 1'b0, 1'b1, a, d, d, 1'b1, 1'b1});
      end else begin
        d = mdl_mem[a[9:2]];
        wq.push_back('{oh, 1'b1, 1'b0, a, d, '0, 1'b1, 1'b0});
      end
    end
    rr = w;
    apply();
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge CLK);
      ok = grant != '0;
    end
    if (!ok) chk("grant_timeout", 64'(grant), 64'(oh));
    if (!hold) begin
      if (wb) pwen[w] = 1'b0;
      else pren[w] = 1'b0;
    end
    if (rnd) add_random(w);
    apply();
    if (abort_after > 0) begin
      ok = 1'b0;
      for (int c = 0; c < 100 && !ok; c++) begin
        ok = wq.size() <= WD - abort_after;
        if (!ok) @(negedge CLK);
      end
      if (!ok) chk("abort_timeout", 64'(wq.size()), 64'(WD - abort_after));
      pulse_reset();
      return;
    end
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge CLK);
      ok = grant == '0;
    end
    if (!ok) chk("release_timeout", 64'(grant), 64'(0));
  endtask
  // Monitor: pops expectations whenever the DUT presents a grant, snoop or word-done.
  logic [NC-1:0] prev_g, eg, ew, ones_m;
  wexp_t we;
  sexp_t se;
  always @(negedge CLK) begin
    if (RST) prev_g = '0;
    else begin
      ones_m = '1;
      if (grant != '0 && prev_g == '0) begin
        if (gq.size() == 0) chk("grant_unexpected", 64'(grant), 64'(0));
        else begin
          eg = gq.pop_front();
          chk("grant", 64'(grant), 64'(eg));
        end
      end else if (grant != '0 && grant != prev_g) chk("grant_back_to_back", 64'(grant), 64'(prev_g));
      prev_g = grant;
      if (snoop_valid != '0 || snoop_inv != '0) begin
        if (sq.size() == 0) chk("snoop_unexpected", 64'(snoop_valid), 64'(0));
        else begin
          se = sq.pop_front();
          chk("snoop_valid", 64'(snoop_valid), 64'(se.v));
          chk("snoop_inv", 64'(snoop_inv), 64'(se.inv));
          chk("snoop_addr", 64'(snoop_addr), 64'(se.a));
        end
      end
      if (cache_wait != ones_m) begin
        if (wq.size() == 0) chk("word_unexpected", 64'(cache_wait), 64'(ones_m));
        else begin
          we = wq.pop_front();
          ew = ~we.g;
          chk("cache_wait", 64'(cache_wait), 64'(ew));
          chk("word_grant", 64'(grant), 64'(we.g));
          chk("ram_ren", 64'(ram_ren), 64'(we.ren));
          chk("ram_wen", 64'(ram_wen), 64'(we.wen));
          chk("ram_addr", 64'(ram_addr), 64'(we.addr));
          if (we.cl) chk("cache_load", 64'(cache_load), 64'(we.load));
          if (we.cs) chk("ram_store", 64'(ram_store), 64'(we.store));
        end
      end
      if (ram_ren && ram_wen) chk("ren_wen_exclusive", 64'({ram_ren, ram_wen}), 64'(0));
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 256; i++) mdl_mem[i] = init_val(8'(i));
    for (int i = 0; i < NC; i++) begin
      pren[i] = 1'b0; pwen[i] = 1'b0; prdx[i] = 1'b0; paddr[i] = '0;
      for (int k = 0; k < WD; k++) begin st[i][k] = '0; sd[i][k] = '0; end
    end
    #1 RST = 1'b1;
    repeat (2) @(negedge CLK);
    check_reset_outputs();
    RST = 1'b0;
    @(negedge CLK);
    check_reset_outputs();
    // Reset mid-MEMRD after word 0; pending cache1 then wins over cache0.
    pren[0] = 1'b1; paddr[0] = 32'h140;
    pren[1] = 1'b1; paddr[1] = 32'h180;
    do_txn(1'b0, 1'b0, '0, 1);
    do_txn(1'b0, 1'b0, '0, 0);
    pren[0] = 1'b1;
    do_txn(1'b0, 1'b0, '0, 0);
    // Plain read miss at 0x104, no snoop hits.
    pren[0] = 1'b1; paddr[0] = 32'h104;
    do_txn(1'b0, 1'b0, '0, 0);
    // Exclusive read at 0x200 supplied cache-to-cache by cache1.
    pren[0] = 1'b1; prdx[0] = 1'b1; paddr[0] = 32'h200;
    sd[1][0] = 32'hAAAA; sd[1][1] = 32'hBBBB;
    do_txn(1'b0, 1'b0, 3'b010, 0);
    prdx[0] = 1'b0;
    // Continuous requests from all caches rotate the grant.
    pulse_reset();
    for (int i = 0; i < NC; i++) begin pren[i] = 1'b1; paddr[i] = 32'h40 * (i + 1); end
    repeat (4) do_txn(1'b1, 1'b0, '0, 0);
    for (int i = 0; i < NC; i++) pren[i] = 1'b0;
    apply();
    // Writeback first, then the still-held read of the same cache.
    pwen[2] = 1'b1; pren[2] = 1'b1; paddr[2] = 32'h300;
    st[2][0] = 32'h11; st[2][1] = 32'h22;
    do_txn(1'b0, 1'b0, '0, 0);
    do_txn(1'b0, 1'b0, '0, 0);
    // Own snoop_hit is masked off: plain RAM read.
    pren[1] = 1'b1; paddr[1] = 32'h2C0;
    do_txn(1'b0, 1'b0, 3'b010, 0);
    // Randomized traffic.
    rdy_rand = 1'b1;
    for (int n = 0; n < 50; n++) begin
      add_random(-1);
      if (!(pren[0] || pwen[0] || pren[1] || pwen[1] || pren[2] || pwen[2])) new_req($urandom_range(0, NC-1));
      for (int i = 0; i < NC; i++) for (int k = 0; k < WD; k++) sd[i][k] = $urandom;
      do_txn(1'b0, 1'b1, NC'($urandom_range(0, (1 << NC) - 1)), 0);
    end
    for (int i = 0; i < NC; i++) begin pren[i] = 1'b0; pwen[i] = 1'b0; end
    apply();
    repeat (30) @(negedge CLK);
    chk("grant_queue_drained", 64'(gq.size()), 64'(0));
    chk("snoop_queue_drained", 64'(sq.size()), 64'(0));
    chk("word_queue_drained", 64'(wq.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_control_nway.md
Name: bus_control_nway

Overview:
- N-cache coherence bus controller; successor to the two-cache snooping bus controller.
- Arbitrates block read, read-exclusive and writeback requests from NCACHE L1 dcaches using round-robin.
- Snoops every non-requesting cache. Serves data either cache-to-cache, with a simultaneous memory update, or from RAM.
- Sits between the dcaches and the single RAM port.

Parameters:
- NCACHE, 2, number of caches on the bus (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data word width.
- WORDS, 2, words per cache block (power of 2, >=2).

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous active-high reset.
- cache_ren  in  NCACHE  per-cache block read request (miss fill).
- cache_wen  in  NCACHE  per-cache block writeback request.
- cache_rdx  in  NCACHE  read is exclusive (write miss); qualifies cache_ren.
- cache_addr  in  NCACHE*ADDR_W  per-cache request address.
- cache_store  in  NCACHE*DATA_W  per-cache writeback word, selected by word_idx.
- cache_load  out  DATA_W  fill word, broadcast to all caches.
- cache_wait  out  NCACHE  active-low word-done strobe, per cache.
- grant  out  NCACHE  one-hot owner of the bus.
- word_idx  out  $clog2(WORDS)  current word within the block.
- snoop_valid  out  NCACHE  snoop strobe to every cache except the granted one.
- snoop_inv  out  NCACHE  invalidate with the snoop (rdx).
- snoop_addr  out  ADDR_W  block-aligned snooped address.
- snoop_hit  in  NCACHE  snooped cache holds the block Modified and will supply it.
- snoop_data  in  NCACHE*DATA_W  supplier word, selected by word_idx.
- ram_ren, ram_wen  out  1  RAM read/write strobes.
- ram_addr  out  ADDR_W  RAM word address.
- ram_store  out  DATA_W  RAM write data.
- ram_load  in  DATA_W  RAM read data.
- ram_ready  in  1  RAM access completes this cycle.

Behaviour:
- Reset (any cycle, including mid-transaction): state=IDLE, word counter=0, rr_ptr=NCACHE-1 (cache 0 has first priority). Outputs: grant=0, cache_wait=all 1, snoop_*=0, ram_ren=ram_wen=0, addresses/data=0.
- Block base address = granted cache_addr with the low $clog2(WORDS)+2 bits cleared. It is latched at grant.
- Word address = base + 4*word_idx.
- Request vector = cache_ren|cache_wen.
- IDLE: if any request, grant the first requester scanning from rr_ptr+1 with wrap, and register grant (one cycle request-to-grant). A set cache_wen goes to WB; otherwise go to SNOOP.
- SNOOP (exactly 1 cycle):
  - snoop_valid = ~grant; snoop_inv = ~grant if cache_rdx[g], else 0.
  - snoop_hit is sampled at the end of the cycle and masked by ~grant.
  - Any hit goes to C2C with the supplier latched as the lowest hitting index. No hit goes to MEMRD.
- MEMRD: ram_ren=1, cache_load=ram_load. On ram_ready: cache_wait[g]=0 that cycle, then word_idx++.
- C2C: ram_wen=1, ram_store=cache_load=snoop_data[supplier]. On ram_ready: cache_wait[g]=0, word_idx++. The supplier observes word_idx and ram_ready.
- WB: ram_wen=1, ram_store=cache_store[g]. On ram_ready: cache_wait[g]=0, word_idx++. No snoop is issued.
- Last word done (word_idx wraps from WORDS-1 to 0):
  - go to IDLE, rr_ptr=g, grant cleared next cycle;
  - no back-to-back grant: at least one IDLE cycle between transactions.
- cache_wait of non-granted caches stays 1 throughout.
- ram_ren and ram_wen are never both 1.
- Requests deasserting mid-transaction are ignored; the transaction completes.
- New requests arriving mid-transaction wait; they are not lost if held.
- A cache with both ren and wen set: writeback first. The read is served only if it is still asserted in a later arbitration.
- Multiple snoop hits (protocol violation): lowest index supplies; no error is flagged.
- ram_ready asserted while the bus is idle: ignored.

Test Plan:
- NCACHE=2, WORDS=2. Cache0 ren at 0x104, no hits, ram_ready every 2nd cycle:
  - grant=01; snoop_valid=10 for 1 cycle with snoop_addr=0x100, snoop_inv=0;
  - ram_addr 0x100 then 0x104; cache_wait[0] low twice; cache_load = ram_load values; then IDLE.
- Cache0 rdx read at 0x200, cache1 snoop_hit=1 with words 0xAAAA/0xBBBB:
  - snoop_inv=10;
  - ram_wen writes 0x200=0xAAAA and 0x204=0xBBBB;
  - cache_load matches each word; ram_ren stays 0.
- NCACHE=3, all three ren held continuously:
  - grants 001, 010, 100, 001, each separated by one IDLE cycle.
- Cache2 wen and ren at 0x300, store words 0x11/0x22:
  - WB first, no snoop_valid; RAM written 0x300=0x11, 0x304=0x22;
  - next grant to cache2 goes to SNOOP.
- RST pulsed mid-MEMRD after word 0:
  - all outputs return to reset values asynchronously;
  - after release, a pending cache1 request is granted before cache0.
- Self-snoop exclusion: cache1 requests while snoop_hit[1]=1:
  - snoop_valid[1]=0, hit ignored, path=MEMRD.
